tr_pwm_generator: RTL

// - Per-transducer output stage, one instance per transducer, fed by the normal-mode parameter buffers.
// - Captures duty/phase/duty-offset once per ultrasound period.
// - Optionally delays the captured parameters by a per-transducer number of whole periods.
// - Emits one glitch-free, phase-shifted PWM drive bit against the shared 8-bit period counter.

---
 rtl/tr_pwm_generator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tr_pwm_generator.sv
// tr_pwm_generator: per-transducer phase-shifted PWM drive stage.
// Optional per-period parameter delay line: define TR_DELAY_LINE_EN.
module tr_pwm_generator #(
  parameter int unsigned DELAY_DEPTH = 128
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TIME,
  input  logic [7:0] DUTY,
  input  logic [7:0] PHASE,
  input  logic       DUTY_OFFSET,
  input  logic [6:0] DELAY,
  input  logic       DELAY_RST,
  output logic       PWM_OUT,
  output logic       BUSY
);

  logic [16:0] live;
  logic [16:0] act;
  logic [16:0] nxt_act;
  logic        off_a;
  logic [7:0]  duty_a;
  logic [7:0]  phase_a;
  logic [7:0]  rel;
  logic [8:0]  w;
  logic        bnd;
  logic        capture;
  logic        zero_act;
  logic        force_lo;

  assign live = {DUTY_OFFSET, DUTY, PHASE};
  assign {off_a, duty_a, phase_a} = act;
  assign bnd = (TIME == 8'd255);
  assign rel = TIME - phase_a;
  assign w = {1'b0, duty_a} + {8'd0, off_a};

`ifdef TR_DELAY_LINE_EN
  localparam int unsigned AW = $clog2(DELAY_DEPTH);

  typedef enum logic {
    RUN,
    CLEAR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] cnt;
  logic          rst_d;
  logic          clr_req;
  logic          clr_last;
  logic [16:0]   mem [DELAY_DEPTH];

  assign clr_req = DELAY_RST & ~rst_d;
  assign clr_last = (cnt == AW'(DELAY_DEPTH - 1));
  // Read happens before this edge's write, so DELAY=d returns d periods back
  assign rd_ptr = wr_ptr - AW'(DELAY);
  assign nxt_act = (DELAY == 7'd0) ? live : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:   if (clr_req) state_nx = CLEAR;
      CLEAR: if (!clr_req && clr_last) state_nx = RUN;
    endcase
  end

  always_comb begin
    BUSY     = 1'b0;
    capture  = 1'b0;
    zero_act = 1'b0;
    force_lo = clr_req;
    unique case (state)
      RUN:   capture = bnd & ~clr_req;
      CLEAR: begin
        BUSY     = 1'b1;
        force_lo = 1'b1;
        zero_act = (state_nx == RUN);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_d  <= 1'b0;
      cnt    <= '0;
      wr_ptr <= '0;
    end else begin
      rst_d <= DELAY_RST;
      if (clr_req)             cnt <= '0;
      else if (state == CLEAR) cnt <= cnt + 1'b1;
      if (zero_act)     wr_ptr <= '0;
      else if (capture) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (capture)             mem[wr_ptr] <= live;
    else if (state == CLEAR) mem[cnt] <= '0;
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{DELAY, DELAY_RST, DELAY_DEPTH[0]};
  assign nxt_act = live;
  assign capture = bnd;
  assign zero_act = 1'b0;
  assign force_lo = 1'b0;
  assign BUSY = 1'b0;
`endif

  // Active params only move at TIME==255, so each period is glitch-free
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      act     <= '0;
      PWM_OUT <= 1'b0;
    end else begin
      if (zero_act)     act <= '0;
      else if (capture) act <= nxt_act;
      PWM_OUT <= ~force_lo & ({1'b0, rel} < w);
    end
  end

endmodule
